// File: rtl/count_seq_checker.sv
// Receive-side monitor for the go/out/done counting protocol: checks each run
// against the expected sequence, reports pass/fail and tracks errors.
module count_seq_checker #(
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      ERR_W     = 8,
  parameter bit               COUNT_UP  = 1'b1,
  parameter logic [WIDTH-1:0] MAX_COUNT = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] out,
  input  logic             done,
  input  logic             clear,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             spurious,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_bad,
  output logic             first_bad_vld
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  localparam logic [WIDTH-1:0] START_VAL = COUNT_UP ? '0 : MAX_COUNT;
  localparam logic [WIDTH-1:0] END_VAL   = COUNT_UP ? MAX_COUNT : '0;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             run_err_q, run_err_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             spurious_q, spurious_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] first_bad_q, first_bad_d;
  logic             first_bad_vld_q, first_bad_vld_d;
  logic             err_ev;

  // Next-state, sequence check and error bookkeeping
  always_comb begin
    state_d         = state_q;
    exp_d           = exp_q;
    run_err_d       = run_err_q;
    busy_d          = busy_q;
    pass_d          = 1'b0;
    fail_d          = 1'b0;
    spurious_d      = 1'b0;
    err_count_d     = err_count_q;
    first_bad_d     = first_bad_q;
    first_bad_vld_d = first_bad_vld_q;
    err_ev          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (done) begin
          spurious_d = 1'b1;
          err_ev     = 1'b1;
        end
        if (go) begin
          exp_d   = START_VAL;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        err_ev = (out != exp_q) || done;
        if (exp_q == END_VAL) begin
          state_d = S_FINAL;
        end else if (COUNT_UP) begin
          exp_d = exp_q + WIDTH'(1);
        end else begin
          exp_d = exp_q - WIDTH'(1);
        end
      end
      S_FINAL: begin
        err_ev  = (out != END_VAL) || !done;
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!run_err_q && !err_ev) pass_d = 1'b1;
        else                       fail_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (err_ev) begin
      run_err_d = 1'b1;
      if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
      if (!first_bad_vld_q) begin
        first_bad_d     = out;
        first_bad_vld_d = 1'b1;
      end
    end

    // A run starting this edge begins clean even if a spurious done coincided
    if (state_q == S_IDLE && go) run_err_d = 1'b0;

    if (clear) begin
      err_count_d     = '0;
      first_bad_d     = '0;
      first_bad_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      exp_q           <= '0;
      run_err_q       <= 1'b0;
      busy_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      spurious_q      <= 1'b0;
      err_count_q     <= '0;
      first_bad_q     <= '0;
      first_bad_vld_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      exp_q           <= exp_d;
      run_err_q       <= run_err_d;
      busy_q          <= busy_d;
      pass_q          <= pass_d;
      fail_q          <= fail_d;
      spurious_q      <= spurious_d;
      err_count_q     <= err_count_d;
      first_bad_q     <= first_bad_d;
      first_bad_vld_q <= first_bad_vld_d;
    end
  end

  assign busy          = busy_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign spurious      = spurious_q;
  assign err_count     = err_count_q;
  assign first_bad     = first_bad_q;
  assign first_bad_vld = first_bad_vld_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: an up checker (MAX=F) driven from a
// vector table plus hand sequences, and a down checker (MAX=9).
module tb_count_seq_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       go, done, clear;
  logic [3:0] out;
  logic       busy, pass, fail, spurious, first_bad_vld;
  logic [7:0] err_count;
  logic [3:0] first_bad;

  logic       d_go, d_done, d_clear;
  logic [3:0] d_out;
  logic       d_busy, d_pass, d_fail, d_spurious, d_first_bad_vld;
  logic [7:0] d_err_count;
  logic [3:0] d_first_bad;

  count_seq_checker #(.WIDTH(4), .ERR_W(8), .COUNT_UP(1'b1), .MAX_COUNT(4'hF)) u_up (
    .clk(clk), .rst(rst), .go(go), .out(out), .done(done), .clear(clear),
    .busy(busy), .pass(pass), .fail(fail), .spurious(spurious),
    .err_count(err_count), .first_bad(first_bad), .first_bad_vld(first_bad_vld)
  );

  count_seq_checker #(.WIDTH(4), .ERR_W(8), .COUNT_UP(1'b0), .MAX_COUNT(4'h9)) u_dn (
    .clk(clk), .rst(rst), .go(d_go), .out(d_out), .done(d_done), .clear(d_clear),
    .busy(d_busy), .pass(d_pass), .fail(d_fail), .spurious(d_spurious),
    .err_count(d_err_count), .first_bad(d_first_bad), .first_bad_vld(d_first_bad_vld)
  );

  typedef struct {
    logic       go;
    logic [3:0] out;
    logic       done;
    logic       clr;
    logic       busy;
    logic       pass;
    logic       fail;
    logic       spur;
    logic [7:0] err;
    logic [3:0] fb;
    logic       fbv;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(input logic g, input logic [3:0] o, input logic dn,
                              input logic c, input logic b, input logic p,
                              input logic f, input logic s, input logic [7:0] e,
                              input logic [3:0] fb, input logic fbv);
    vec_t v;
    v.go = g; v.out = o; v.done = dn; v.clr = c;
    v.busy = b; v.pass = p; v.fail = f; v.spur = s; v.err = e; v.fb = fb; v.fbv = fbv;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic g, input logic [3:0] o, input logic dn, input logic c);
    go = g; out = o; done = dn; clear = c;
    tick();
  endtask

  // Clean up run on the up checker, ending with the verdict checked
  task automatic clean_up_run(input string nm);
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    chk({nm, ".busy0"}, 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) drive(1'b0, 4'(i), 1'b0, 1'b0);
    drive(1'b0, 4'hF, 1'b1, 1'b0);
    chk({nm, ".pass"}, 32'(pass), 32'd1);
    chk({nm, ".fail"}, 32'(fail), 32'd0);
    chk({nm, ".busy_end"}, 32'(busy), 32'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk({nm, ".pass_gone"}, 32'(pass), 32'd0);
  endtask

  initial begin
    // Clean up run: busy for 17 samples, pass on the verdict
    add(1, 4'h0, 0, 0, 1, 0, 0, 0, 8'd0, 4'h0, 0);
    for (int i = 0; i < 16; i++) add(0, 4'(i), 0, 0, 1, 0, 0, 0, 8'd0, 4'h0, 0);
    add(0, 4'hF, 1, 0, 0, 1, 0, 0, 8'd0, 4'h0, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 8'd0, 4'h0, 0);
    // Skipped value 5: producer reaches F early and raises done one edge early
    add(1, 4'h0, 0, 0, 1, 0, 0, 0, 8'd0, 4'h0, 0);
    for (int e = 0; e < 16; e++) begin
      if (e < 5)       add(0, 4'(e), 0, 0, 1, 0, 0, 0, 8'd0, 4'h0, 0);
      else if (e < 15) add(0, 4'(e + 1), 0, 0, 1, 0, 0, 0, 8'(e - 4), 4'h6, 1);
      else             add(0, 4'hF, 1, 0, 1, 0, 0, 0, 8'd11, 4'h6, 1);
    end
    add(0, 4'hF, 1, 0, 0, 0, 1, 0, 8'd11, 4'h6, 1);
    add(0, 4'h0, 0, 1, 0, 0, 0, 0, 8'd0, 4'h0, 0);
    // Missing done at the verdict edge
    add(1, 4'h0, 0, 0, 1, 0, 0, 0, 8'd0, 4'h0, 0);
    for (int i = 0; i < 16; i++) add(0, 4'(i), 0, 0, 1, 0, 0, 0, 8'd0, 4'h0, 0);
    add(0, 4'hF, 0, 0, 0, 0, 1, 0, 8'd1, 4'hF, 1);
    // Spurious done while idle, then go coincident with done
    add(0, 4'h0, 1, 0, 0, 0, 0, 1, 8'd2, 4'hF, 1);
    add(1, 4'h0, 1, 0, 1, 0, 0, 1, 8'd3, 4'hF, 1);
    for (int i = 0; i < 16; i++) add(0, 4'(i), 0, 0, 1, 0, 0, 0, 8'd3, 4'hF, 1);
    add(0, 4'hF, 1, 0, 0, 1, 0, 0, 8'd3, 4'hF, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 8'd3, 4'hF, 1);

    rst = 1'b1;
    go = 1'b0; out = 4'h0; done = 1'b0; clear = 1'b0;
    d_go = 1'b0; d_out = 4'h0; d_done = 1'b0; d_clear = 1'b0;
    tick();
    tick();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.pass", 32'(pass), 32'd0);
    chk("rst.fail", 32'(fail), 32'd0);
    chk("rst.spur", 32'(spurious), 32'd0);
    chk("rst.err", 32'(err_count), 32'd0);
    chk("rst.fb", 32'(first_bad), 32'd0);
    chk("rst.fbv", 32'(first_bad_vld), 32'd0);
    chk("rst.d_busy", 32'(d_busy), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].go, vecs[i].out, vecs[i].done, vecs[i].clr);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d.pass", i), 32'(pass), 32'(vecs[i].pass));
      chk($sformatf("v%0d.fail", i), 32'(fail), 32'(vecs[i].fail));
      chk($sformatf("v%0d.spur", i), 32'(spurious), 32'(vecs[i].spur));
      chk($sformatf("v%0d.err", i), 32'(err_count), 32'(vecs[i].err));
      chk($sformatf("v%0d.fb", i), 32'(first_bad), 32'(vecs[i].fb));
      chk($sformatf("v%0d.fbv", i), 32'(first_bad_vld), 32'(vecs[i].fbv));
    end

    // Saturation: 300 spurious-done error cycles from a count of 3
    for (int i = 0; i < 300; i++) drive(1'b0, 4'h0, 1'b1, 1'b0);
    chk("sat.err", 32'(err_count), 32'hFF);
    chk("sat.spur", 32'(spurious), 32'd1);
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    chk("clr.err", 32'(err_count), 32'd0);
    chk("clr.fbv", 32'(first_bad_vld), 32'd0);
    chk("clr.fb", 32'(first_bad), 32'd0);
    chk("clr.spur", 32'(spurious), 32'd1);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("idle.err", 32'(err_count), 32'd0);

    // Reset mid-run at out=7
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 4'(i), 1'b0, 1'b0);
    chk("mid.busy_pre", 32'(busy), 32'd1);
    out = 4'h7;
    rst = 1'b1;
    #1;
    chk("mid.busy", 32'(busy), 32'd0);
    tick();
    chk("mid.pass", 32'(pass), 32'd0);
    chk("mid.fail", 32'(fail), 32'd0);
    rst = 1'b0;
    clean_up_run("after_rst");
    chk("after_rst.err", 32'(err_count), 32'd0);

    // Down checker, MAX=9
    d_go = 1'b1;
    tick();
    d_go = 1'b0;
    chk("dn.busy0", 32'(d_busy), 32'd1);
    for (int i = 9; i >= 0; i--) begin
      d_out = 4'(i);
      tick();
      chk($sformatf("dn.busy_%0d", i), 32'(d_busy), 32'd1);
    end
    d_out = 4'h0;
    d_done = 1'b1;
    tick();
    d_done = 1'b0;
    chk("dn.pass", 32'(d_pass), 32'd1);
    chk("dn.fail", 32'(d_fail), 32'd0);
    chk("dn.err", 32'(d_err_count), 32'd0);
    chk("dn.busy_end", 32'(d_busy), 32'd0);
    tick();
    chk("dn.pass_gone", 32'(d_pass), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
